// File: rtl/framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_scanout
// Purpose  : 640x480@60 VGA scanout of a 320x240 3-bpp framebuffer (2x2 pixels)
// Revision : 1.0 - initial release
// ============================================================================
module framebuffer_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [18:0] ram_address,
    output logic        ram_read_enable,
    input  logic [2:0]  ram_read_data,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start,
    output logic        vblank
);

    localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] c_HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] c_VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] c_V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [18:0] addr_q, addr_d;
    logic        ren_q, ren_d;
    logic        act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic        act2_q, act2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        fs_q, fs_d, vblank_q, vblank_d;

    logic        w_active, w_hs, w_vs;
    logic [18:0] w_vhalf, w_addr;

    // Stage 0: decode the raw counter position
    assign w_active = (h_q < c_H_VIS) && (v_q < c_V_VIS);
    assign w_hs     = ~((h_q >= c_HS_START) && (h_q < c_HS_END));
    assign w_vs     = ~((v_q >= c_VS_START) && (v_q < c_VS_END));
    // 320*y built as 256*y + 64*y to avoid a multiplier
    assign w_vhalf  = {10'd0, v_q[9:1]};
    assign w_addr   = (w_vhalf << 8) + (w_vhalf << 6) + {10'd0, h_q[9:1]};

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == c_H_LAST) begin
            h_d = 10'd0;
            v_d = (v_q == c_V_LAST) ? 10'd0 : v_q + 10'd1;
        end

        addr_d = w_active ? w_addr : 19'd0;
        ren_d  = w_active;
        act1_d = w_active;
        hs1_d  = w_hs;
        vs1_d  = w_vs;

        act2_d = act1_q;
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;

        rgb_d   = act2_q ? {{4{ram_read_data[2]}}, {4{ram_read_data[1]}},
                            {4{ram_read_data[0]}}} : 12'h000;
        hsync_d = hs2_q;
        vsync_d = vs2_q;

        fs_d     = (h_q == 10'd0) && (v_q == c_V_VIS);
        vblank_d = (v_q >= c_V_VIS);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_q      <= 10'd0;
            v_q      <= 10'd0;
            addr_q   <= 19'd0;
            ren_q    <= 1'b0;
            act1_q   <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            act2_q   <= 1'b0;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
            rgb_q    <= 12'h000;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            fs_q     <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            addr_q   <= addr_d;
            ren_q    <= ren_d;
            act1_q   <= act1_d;
            hs1_q    <= hs1_d;
            vs1_q    <= vs1_d;
            act2_q   <= act2_d;
            hs2_q    <= hs2_d;
            vs2_q    <= vs2_d;
            rgb_q    <= rgb_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            fs_q     <= fs_d;
            vblank_q <= vblank_d;
        end
    end

    assign ram_address     = addr_q;
    assign ram_read_enable = ren_q;
    assign vga_r           = rgb_q[11:8];
    assign vga_g           = rgb_q[7:4];
    assign vga_b           = rgb_q[3:0];
    assign vga_hsync       = hsync_q;
    assign vga_vsync       = vsync_q;
    assign frame_start     = fs_q;
    assign vblank          = vblank_q;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_framebuffer_scanout
// Purpose  : Directed self-checking bench; shortened vertical timing (15 lines)
// Revision : 1.0 - initial release
// ============================================================================
module tb_framebuffer_scanout;

    localparam int VV    = 8;
    localparam int VT    = 15;
    localparam int FRAME = 800 * VT;

    logic        clock;
    logic        reset_n;
    logic [18:0] ram_address;
    logic        ram_read_enable;
    logic [2:0]  ram_read_data;
    logic        vga_hsync, vga_vsync;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        frame_start, vblank;

    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;
    int mode     = 0;

    framebuffer_scanout #(
        .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_VISIBLE(VV),  .V_FRONT(2),  .V_SYNC(2),  .V_BACK(3)
    ) u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ram_address    (ram_address),
        .ram_read_enable(ram_read_enable),
        .ram_read_data  (ram_read_data),
        .vga_hsync      (vga_hsync),
        .vga_vsync      (vga_vsync),
        .vga_r          (vga_r),
        .vga_g          (vga_g),
        .vga_b          (vga_b),
        .frame_start    (frame_start),
        .vblank         (vblank)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2:0] pix(input int m, input int x, input int y);
        case (m)
            0:       return 3'b011;
            1:       return 3'b100;
            2:       return 3'b111;
            default: return 3'((x + y) % 8);
        endcase
    endfunction

    // Synchronous-read RAM model: data one clock after the address
    always @(posedge clock)
        ram_read_data <= pix(mode, int'(ram_address) % 320, int'(ram_address) / 320);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s k=%0d got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_addr"},  32'(ram_address), 32'd0);
        check_eq({tag, "_ren"},   32'(ram_read_enable), 32'd0);
        check_eq({tag, "_hs"},    32'(vga_hsync), 32'd1);
        check_eq({tag, "_vs"},    32'(vga_vsync), 32'd1);
        check_eq({tag, "_rgb"},   32'({vga_r, vga_g, vga_b}), 32'd0);
        check_eq({tag, "_fs"},    32'(frame_start), 32'd0);
        check_eq({tag, "_vb"},    32'(vblank), 32'd0);
    endtask

    // Expected outputs after edge k derived from cycle index since reset release
    task automatic check_cycle();
        int c, hc, vc, x, y;
        logic [2:0] d;
        logic [31:0] e_addr, e_ren, e_hs, e_vs, e_rgb;
        c  = k - 1;
        hc = c % 800;
        vc = (c / 800) % VT;
        if (hc < 640 && vc < VV) begin
            e_addr = 32'((vc / 2) * 320 + hc / 2);
            e_ren  = 32'd1;
        end else begin
            e_addr = 32'd0;
            e_ren  = 32'd0;
        end
        check_eq("addr", 32'(ram_address), e_addr);
        check_eq("ren", 32'(ram_read_enable), e_ren);
        check_eq("frame_start", 32'(frame_start), 32'(hc == 0 && vc == VV));
        check_eq("vblank", 32'(vblank), 32'(vc >= VV));
        if (k < 3) begin
            e_hs = 32'd1; e_vs = 32'd1; e_rgb = 32'd0;
        end else begin
            c  = k - 3;
            hc = c % 800;
            vc = (c / 800) % VT;
            e_hs = 32'(!(hc >= 656 && hc < 752));
            e_vs = 32'(!(vc >= 10 && vc < 12));
            e_rgb = 32'd0;
            if (hc < 640 && vc < VV) begin
                x = hc / 2;
                y = vc / 2;
                d = pix(mode, x, y);
                e_rgb = 32'({{4{d[2]}}, {4{d[1]}}, {4{d[0]}}});
            end
        end
        check_eq("hsync", 32'(vga_hsync), e_hs);
        check_eq("vsync", 32'(vga_vsync), e_vs);
        check_eq("rgb", 32'({vga_r, vga_g, vga_b}), e_rgb);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        k++;
    endtask

    int mode_tbl [4] = '{0, 1, 3, 2};
    int fs_count, vb_count, vs_low, hs_low, last_fs, first_hs_low, first_vs_low;

    initial begin
        reset_n = 1'b1;
        mode    = 0;
        #2 reset_n = 1'b0;
        #1 check_reset_state("por");
        repeat (3) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        k = 0;

        // Run into line 1, then reset asynchronously mid-visible-line
        repeat (900) begin
            step();
            check_cycle();
        end
        check_eq("pre_reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0FF);
        #3 reset_n = 1'b0;
        #1 check_reset_state("async");
        repeat (2) @(posedge clock);
        #1 check_reset_state("held");
        @(negedge clock) reset_n = 1'b1;
        k = 0;

        fs_count = 0; vb_count = 0; vs_low = 0; hs_low = 0;
        last_fs = -1; first_hs_low = -1; first_vs_low = -1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            step();
            check_cycle();
            if (frame_start) begin
                fs_count++;
                if (last_fs >= 0) check_eq("fs_period", 32'(k - last_fs), 32'(FRAME));
                last_fs = k;
            end
            if (vblank) vb_count++;
            if (!vga_vsync) begin
                vs_low++;
                if (first_vs_low < 0) first_vs_low = k;
            end
            if (!vga_hsync) begin
                hs_low++;
                if (first_hs_low < 0) first_hs_low = k;
            end
            case (k)
                2:    check_eq("rgb_k2", 32'({vga_r, vga_g, vga_b}), 32'h000);
                3:    check_eq("rgb_k3", 32'({vga_r, vga_g, vga_b}), 32'h0FF);
                4:    check_eq("addr_h3", 32'(ram_address), 32'd1);
                641:  check_eq("ren_hblank", 32'(ram_read_enable), 32'd0);
                1601: check_eq("addr_v2", 32'(ram_address), 32'd320);
                6240: check_eq("addr_last", 32'(ram_address), 32'd1279);
                6401: check_eq("fs_first", 32'(frame_start), 32'd1);
                6402: check_eq("fs_width", 32'(frame_start), 32'd0);
                default: ;
            endcase
            if ((k % FRAME) == FRAME - 100 && (k / FRAME) + 1 < 4)
                mode = mode_tbl[(k / FRAME) + 1];
        end
        check_eq("fs_count", 32'(fs_count), 32'd4);
        check_eq("vblank_cycles", 32'(vb_count), 32'(4 * 7 * 800));
        check_eq("vsync_low_cycles", 32'(vs_low), 32'(4 * 1600));
        check_eq("hsync_low_cycles", 32'(hs_low), 32'(4 * VT * 96));
        check_eq("hsync_first_fall", 32'(first_hs_low), 32'd659);
        check_eq("vsync_first_fall", 32'(first_vs_low), 32'd8003);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
